// File: rtl/imem_loader.sv
// Byte-stream to instruction-RAM loader: a length byte N, then 4*N little-endian bytes,
// packed into 32-bit words with one write strobe each while the CPU is held in reset.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded,
  output logic [2:0]       fsm_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  // Byte handshake: a byte moves on a rising edge where rx_valid && rx_ready.
  // rx_ready depends on state only, so an offered byte simply waits outside LEN/DATA.

  logic [2:0]       state;
  logic [CNT_W-1:0] n_words;
  logic [1:0]       byte_cnt;
  logic [23:0]      asm_word;
  logic             take;
  logic             len_bad;
  logic [CNT_W-1:0] next_count;
  logic [31:0]      word_addr;

  assign take       = rx_valid && rx_ready;
  assign len_bad    = (rx_data == 8'd0) || (32'(rx_data) > 32'(DEPTH));
  assign next_count = words_loaded + CNT_W'(1);
  // words_loaded doubles as the index of the word currently being assembled.
  assign word_addr  = {{(30 - CNT_W){1'b0}}, words_loaded, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      n_words      <= '0;
      byte_cnt     <= '0;
      asm_word     <= '0;
      words_loaded <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN;
            words_loaded <= '0;
            byte_cnt     <= '0;
            asm_word     <= '0;
          end
        end
        S_LEN: begin
          if (take) begin
            if (len_bad) begin
              state <= S_ERR;
            end else begin
              n_words <= CNT_W'(rx_data);
              state   <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (take) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_word[7:0]   <= rx_data;
              2'd1: asm_word[15:8]  <= rx_data;
              2'd2: asm_word[23:16] <= rx_data;
              default: begin
                // Top byte goes straight into the write register alongside the strobe.
                wr_en   <= 1'b1;
                wr_addr <= word_addr;
                wr_data <= {rx_data, asm_word};
                state   <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          words_loaded <= next_count;
          state        <= (next_count == n_words) ? S_DONE : S_DATA;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rx_ready  = (state == S_LEN) || (state == S_DATA);
  assign busy      = (state == S_LEN) || (state == S_DATA) || (state == S_WRITE);
  // ERR keeps the CPU held so a partial image never runs.
  assign cpu_hold  = busy || (state == S_ERR);
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign fsm_state = state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed plus randomized checks of imem_loader against a stream-level model that
// derives the expected word writes and final status from the byte image alone.
module tb_imem_loader;
  localparam int DEPTH = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] words_loaded;
  logic [2:0]       fsm_state;

  int checks = 0;
  int errors = 0;
  int proto_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [7:0]  stream[$];
  int          exp_n;
  bit          exp_err;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  // write monitor: collects every strobe, flags bytes offered during a write and stray bus values
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_q.push_back({wr_addr, wr_data});
      if (rx_ready !== 1'b0) proto_bad++;
    end else if (wr_en === 1'b0 && (wr_addr !== 32'd0 || wr_data !== 32'd0)) begin
      proto_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, 32'(obs), 32'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_rx_ready"}, rx_ready, 1'b0);
    check_bit({tag, "_wr_en"}, wr_en, 1'b0);
    check({tag, "_wr_addr"}, wr_addr, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check_bit({tag, "_cpu_hold"}, cpu_hold, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
    check_bit({tag, "_err"}, err, 1'b0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  // reference model: length byte, then little-endian words at consecutive word addresses
  task automatic build_model();
    exp_q.delete();
    exp_n   = int'(stream[0]);
    exp_err = (exp_n == 0) || (exp_n > DEPTH);
    if (!exp_err) begin
      for (int i = 0; i < exp_n; i++) begin
        logic [31:0] w;
        w = {stream[4*i+4], stream[4*i+3], stream[4*i+2], stream[4*i+1]};
        exp_q.push_back({32'(i * 4), w});
      end
    end
  endtask

  task automatic make_stream(input int n_words, input logic [7:0] len_byte);
    stream.delete();
    stream.push_back(len_byte);
    for (int i = 0; i < 4 * n_words; i++) stream.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int guard;
    repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    guard    = 0;
    while (rx_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_bit("byte_accepted", rx_ready, 1'b1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic check_done_state();
    check_bit("done", done, 1'b1);
    check("words_loaded", 32'(words_loaded), 32'(exp_n));
    check_bit("done_cpu_hold", cpu_hold, 1'b0);
    check_bit("done_busy", busy, 1'b0);
    check_bit("done_err", err, 1'b0);
  endtask

  task automatic compare_writes();
    check("write_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check("wr_addr", obs_q[i][63:32], exp_q[i][63:32]);
      check("wr_data", obs_q[i][31:0], exp_q[i][31:0]);
    end
    check("protocol_violations", 32'(proto_bad), 32'd0);
    obs_q.delete();
  endtask

  task automatic run_load(input int gap_max, input bit mid_start);
    build_model();
    pulse_start();
    check_bit("start_busy", busy, 1'b1);
    check_bit("start_cpu_hold", cpu_hold, 1'b1);
    check_bit("start_done_clear", done, 1'b0);
    check_bit("start_err_clear", err, 1'b0);
    check("start_count_clear", 32'(words_loaded), 32'd0);
    if (exp_err) begin
      send_byte(stream[0], gap_max);
      @(negedge clk);
      check_bit("err", err, 1'b1);
      check_bit("err_cpu_hold", cpu_hold, 1'b1);
      check_bit("err_busy", busy, 1'b0);
      check_bit("err_done", done, 1'b0);
    end else begin
      for (int k = 0; k < stream.size(); k++) begin
        send_byte(stream[k], gap_max);
        if (mid_start && k == 2) begin
          pulse_start();
          check_bit("ignored_start_busy", busy, 1'b1);
        end
      end
      wait_done();
      check_done_state();
    end
    compare_writes();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // directed two-word image, then the same image again
    stream = '{8'h02, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    run_load(0, 1'b0);
    check("model_word0", exp_q[0][31:0], 32'h0050_0113);
    run_load(0, 1'b0);

    // illegal length headers
    stream = '{8'h00};
    run_load(0, 1'b0);
    stream = '{8'h41};
    run_load(0, 1'b0);
    stream = '{8'($urandom_range(255, 65))};
    run_load(1, 1'b0);

    // reset in the middle of the first word
    stream = '{8'h01, 8'hAA, 8'hBB, 8'hCC};
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(stream[k], 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_reset_writes", 32'(obs_q.size()), 32'd0);
    check_bit("mid_reset_busy", busy, 1'b0);
    obs_q.delete();

    // start pulsed during a load is ignored
    make_stream(1, 8'd1);
    run_load(0, 1'b1);

    // full-depth image with random valid gaps
    make_stream(64, 8'd64);
    run_load(3, 1'b0);
    check("last_addr", exp_q[63][63:32], 32'h0000_00FC);

    // random legal lengths
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(DEPTH, 1);
      make_stream(n, 8'(n));
      run_load($urandom_range(2, 0), 1'b0);
    end

    // byte offered in DONE stays pending and becomes the next length byte
    stream = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    build_model();
    @(negedge clk);
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_bit("pending_rx_ready", rx_ready, 1'b0);
    check_bit("pending_done_held", done, 1'b1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_bit("pending_rx_ready_len", rx_ready, 1'b1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    for (int k = 1; k < 5; k++) send_byte(stream[k], 0);
    wait_done();
    check_done_state();
    compare_writes();

    // reset and start together: reset wins
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check_all_zero("rst_and_start");
    @(negedge clk);
    check_bit("rst_and_start_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
